avr_uart_tx: RTL and testbench
==============================

// Module: avr_uart_tx
// PURPOSE
//  Byte-wide UART transmitter from the glue FPGA to the AVR supervisor on avr_rx; complements the AVR->FPGA path on avr_tx.
//  Bytes are queued in a small FIFO by glue logic (e.g. a CPU I/O register in the csio window) and serialised 8N1, LSB first.
//  Honours AVR flow control: no new frame starts while avr_rx_busy (synchronised) is high.
// PARAMETERS
//  CLKS_PER_BIT    100  sysclk cycles per bit (50 MHz / 100 = 500 kbaud); must be >= 2
//  FIFO_AW         3    FIFO address width; depth = 2**FIFO_AW (8 bytes)
// PORTS
//  sysclk       in   1          system clock, 50 MHz; all logic rising-edge
//  sysrst       in   1          async reset, active high (one clock; reset async active-high)
//  wr_en        in   1          enqueue wr_data this cycle
//  wr_data      in   8          byte to send
//  full         out  1          FIFO holds 2**FIFO_AW bytes
//  level        out  FIFO_AW+1  bytes queued (excludes byte being shifted)
//  overflow     out  1          1-cycle pulse: wr_en while full, byte dropped
//  tx_idle      out  1          FIFO empty and FSM in IDLE
//  avr_rx       out  1          serial line to AVR, idle high
//  avr_rx_busy  in   1          AVR cannot accept a byte (async, active high)
// BEHAVIOUR
//  Reset (async assert): avr_rx=1, full=0, level=0, overflow=0, tx_idle=1, FSM=IDLE, FIFO pointers 0, busy sync flops 0.
//  FIFO: wr_en && !full -> write at edge, level+1. wr_en && full -> dropped, overflow=1 next cycle; full evaluated
//   before any same-cycle pop (write while full is rejected even if a pop occurs that cycle).
//  Same-cycle write+pop with 0<level<DEPTH: level unchanged, both take effect.
//  Pointers wrap modulo 2**FIFO_AW; full/level from FIFO_AW+1-bit count, no extra empty slot.
//  busy_s = 2-flop sync of avr_rx_busy; 2-cycle latency.
//  Bit timer: counts CLKS_PER_BIT-1 down to 0; reloads on each state/bit advance; every bit exactly CLKS_PER_BIT cycles.
//  FSM:
//   IDLE : avr_rx=1. If level!=0 && !busy_s: pop byte to shift reg, -> START. Else stay.
//   START: avr_rx=0 one bit period -> DATA, bit index 0.
//   DATA : avr_rx=shift[0]; at timer 0 shift right, index+1; after index 7 -> STOP (or PARITY if enabled).
//   STOP : avr_rx=1 one bit period -> IDLE.
//  Latency: write at edge N into empty FIFO, FSM IDLE, busy_s=0 -> pop and avr_rx falls at edge N+1.
//  Back-to-back: IDLE lasts exactly 1 cycle between frames when FIFO non-empty and busy_s=0; frame period 10*CLKS_PER_BIT+1 cycles.
//  avr_rx_busy only gates frame start; rising mid-frame does not abort or stretch the frame.
//  tx_idle=1 iff FSM==IDLE && level==0 (registered state, combinational decode).
//  Reset mid-frame: line returns high immediately, queued bytes discarded; no partial frame resumes.
//  avr_rx is always driven (never high-Z) after instantiation; top level replaces its 1'bz tie-off.
// CONFIGURATION
//  AVR_UART_TX_PARITY_EN defined: PARITY state after DATA, one bit period, avr_rx = ^data (even parity);
//   frame = 11 bits, back-to-back period 11*CLKS_PER_BIT+1.
//  Not defined: no PARITY state, 8N1 only; DATA goes straight to STOP.
// TESTING
//  1. Reset, write 0xA5 once, CLKS_PER_BIT=4 -> avr_rx low at next edge; bits 1,0,1,0,0,1,0,1 each 4 cycles; stop high 4 cycles; tx_idle=1 after.
//  2. Write 9 bytes 0x00..0x08 on consecutive cycles, FIFO_AW=3 -> first byte popped after write 1, so 0x08 accepted (level 7), no overflow;
//     then 10th write with level 8 -> overflow pulse 1 cycle, byte absent from line.
//  3. Hold avr_rx_busy=1, write 0x55 -> avr_rx stays 1, level=1; drop busy -> start bit 3 cycles after release (2 sync + 1).
//  4. Raise avr_rx_busy during DATA of 0x3C -> frame completes unchanged; next queued byte waits until busy released.
//  5. Assert sysrst during bit 4 of a frame with 3 bytes queued -> avr_rx=1 asynchronously, level=0, tx_idle=1; no output after release.
//  6. With AVR_UART_TX_PARITY_EN, send 0x07 -> parity bit 1 between bit 7 and stop; 0x03 -> parity bit 0.

Source files
------------

// File: rtl/avr_uart_tx_if.sv
// rtl/avr_uart_tx_if.sv - byte enqueue, status and AVR serial line bundle for avr_uart_tx
interface avr_uart_tx_if #(
    parameter int FIFO_AW = 3
);
    logic               wr_en;
    logic [7:0]         wr_data;
    logic               full;
    logic [FIFO_AW:0]   level;
    logic               overflow;
    logic               tx_idle;
    logic               avr_rx;
    logic               avr_rx_busy;

    modport master (
        output wr_en, wr_data, avr_rx_busy,
        input  full, level, overflow, tx_idle, avr_rx
    );

    modport slave (
        input  wr_en, wr_data, avr_rx_busy,
        output full, level, overflow, tx_idle, avr_rx
    );
endinterface

// File: rtl/avr_uart_tx.sv
// rtl/avr_uart_tx.sv - FIFO-fed 8N1 UART transmitter to the AVR with busy flow control
// Optional even parity bit when AVR_UART_TX_PARITY_EN is defined.
module avr_uart_tx #(
    parameter int CLKS_PER_BIT = 100,
    parameter int FIFO_AW      = 3
) (
    input  logic          sysclk,
    input  logic          sysrst,
    avr_uart_tx_if.slave  bus
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int TW    = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]      T_RELOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               overflow_q;
    logic               busy_m, busy_s;
    logic               full, push, pop;

    state_t             state, state_n;
    logic [TW-1:0]      timer, timer_n;
    logic [2:0]         idx, idx_n;
    logic [7:0]         shift, shift_n;
    logic               line;
`ifdef AVR_UART_TX_PARITY_EN
    logic               par_q, par_n;
`endif

    // Full is judged on the registered count, so a write while full is lost even if a pop coincides.
    assign full = (count == CNT_FULL);
    assign push = bus.wr_en && !full;

    always_ff @(posedge sysclk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
            busy_m     <= 1'b0;
            busy_s     <= 1'b0;
            state      <= S_IDLE;
            timer      <= '0;
            idx        <= '0;
            shift      <= '0;
`ifdef AVR_UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
            overflow_q <= bus.wr_en && full;
            busy_m     <= bus.avr_rx_busy;
            busy_s     <= busy_m;
            state      <= state_n;
            timer      <= timer_n;
            idx        <= idx_n;
            shift      <= shift_n;
`ifdef AVR_UART_TX_PARITY_EN
            par_q      <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        idx_n   = idx;
        shift_n = shift;
        pop     = 1'b0;
        line    = 1'b1;
`ifdef AVR_UART_TX_PARITY_EN
        par_n   = par_q;
`endif
        unique case (state)
            S_IDLE: begin
                // busy only gates the start of a frame; an ongoing frame always completes
                if (count != '0 && !busy_s) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
`ifdef AVR_UART_TX_PARITY_EN
                    par_n   = ^mem[rd_ptr];
`endif
                    timer_n = T_RELOAD;
                    state_n = S_START;
                end
            end
            S_START: begin
                line = 1'b0;
                if (timer == '0) begin
                    timer_n = T_RELOAD;
                    idx_n   = '0;
                    state_n = S_DATA;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            S_DATA: begin
                line = shift[0];
                if (timer == '0) begin
                    timer_n = T_RELOAD;
                    shift_n = {1'b0, shift[7:1]};
                    if (idx == 3'd7) begin
`ifdef AVR_UART_TX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
`ifdef AVR_UART_TX_PARITY_EN
            S_PARITY: begin
                line = par_q;
                if (timer == '0) begin
                    timer_n = T_RELOAD;
                    state_n = S_STOP;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
`endif
            S_STOP: begin
                line = 1'b1;
                if (timer == '0) begin
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign bus.full     = full;
    assign bus.level    = count;
    assign bus.overflow = overflow_q;
    assign bus.tx_idle  = (state == S_IDLE) && (count == '0);
    assign bus.avr_rx   = line;
endmodule

// File: tb/tb_avr_uart_tx.sv
// tb/tb_avr_uart_tx.sv - randomized self-checking bench for avr_uart_tx with a line-level UART receiver model
module tb_avr_uart_tx;
    localparam int C     = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
`ifdef AVR_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * C + 1;

    logic sysclk = 1'b0;
    logic sysrst;
    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    avr_uart_tx_if #(.FIFO_AW(AW)) bus();

    avr_uart_tx #(.CLKS_PER_BIT(C), .FIFO_AW(AW)) dut (
        .sysclk (sysclk),
        .sysrst (sysrst),
        .bus    (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] rx_byte[$];
    int         rx_cyc[$];
    bit         rx_bad[$];
    bit         rx_par[$];

    logic [NB-1:0] mon_bits;
    bit            mon_bad, mon_abort;
    int            mon_st;

    // Receiver: each bit must hold for exactly C samples; a frame cut by reset is discarded.
    initial begin : monitor
        forever begin
            @(negedge sysclk);
            if (sysrst === 1'b0 && bus.avr_rx === 1'b0) begin
                mon_st = cyc; mon_bad = 0; mon_abort = 0; mon_bits = '0;
                for (int b = 0; b < NB && !mon_abort; b++) begin
                    for (int s = 0; s < C && !mon_abort; s++) begin
                        if (b != 0 || s != 0) @(negedge sysclk);
                        if (sysrst !== 1'b0) mon_abort = 1;
                        else if (s == 0) mon_bits[b] = bus.avr_rx;
                        else if (bus.avr_rx !== mon_bits[b]) mon_bad = 1;
                    end
                end
                if (!mon_abort) begin
                    if (mon_bits[0] !== 1'b0 || mon_bits[NB-1] !== 1'b1) mon_bad = 1;
                    rx_byte.push_back(mon_bits[8:1]);
                    rx_cyc.push_back(mon_st);
                    rx_bad.push_back(mon_bad);
                    rx_par.push_back(mon_bits[9]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic clear_rx();
        rx_byte.delete(); rx_cyc.delete(); rx_bad.delete(); rx_par.delete();
    endtask

    task automatic do_write(input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_data = d;
        @(negedge sysclk);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int k = 0;
        while (rx_byte.size() < n && k < budget) begin @(negedge sysclk); k++; end
        vectors++;
        if (rx_byte.size() < n) begin
            miscompares++;
            $display("FAIL %s_timeout: frames %0d, required %0d", name, rx_byte.size(), n);
        end
    endtask

    task automatic test_reset();
        sysrst = 1'b1; bus.wr_en = 1'b0; bus.wr_data = '0; bus.avr_rx_busy = 1'b0;
        tick(3);
        vectors += 5;
        if (bus.avr_rx !== 1'b1)   begin miscompares++; $display("FAIL rst_avr_rx: got %b want 1", bus.avr_rx); end
        if (bus.full !== 1'b0)     begin miscompares++; $display("FAIL rst_full: got %b want 0", bus.full); end
        if (bus.level !== 4'd0)    begin miscompares++; $display("FAIL rst_level: got %0d want 0", bus.level); end
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL rst_overflow: got %b want 0", bus.overflow); end
        if (bus.tx_idle !== 1'b1)  begin miscompares++; $display("FAIL rst_tx_idle: got %b want 1", bus.tx_idle); end
        sysrst = 1'b0;
        tick(3);
        vectors++;
        if (bus.avr_rx !== 1'b1) begin miscompares++; $display("FAIL post_rst_line: got %b want 1", bus.avr_rx); end
    endtask

    task automatic test_single(input logic [7:0] d);
        int w;
        clear_rx();
        do_write(d);
        w = cyc;
        vectors += 2;
        if (bus.level !== 4'd1)   begin miscompares++; $display("FAIL single_level: got %0d want 1", bus.level); end
        if (bus.tx_idle !== 1'b0) begin miscompares++; $display("FAIL single_busy_idle: got %b want 0", bus.tx_idle); end
        wait_frames(1, FRAME + 20, "single");
        if (rx_byte.size() >= 1) begin
            vectors += 3;
            if (rx_byte[0] !== d)    begin miscompares++; $display("FAIL single_data: got %h want %h", rx_byte[0], d); end
            if (rx_cyc[0] != w + 1)  begin miscompares++; $display("FAIL single_latency: start %0d want %0d", rx_cyc[0], w + 1); end
            if (rx_bad[0] !== 1'b0)  begin miscompares++; $display("FAIL single_framing: bad %b want 0", rx_bad[0]); end
`ifdef AVR_UART_TX_PARITY_EN
            vectors++;
            if (rx_par[0] !== ^d)    begin miscompares++; $display("FAIL single_parity: got %b want %b", rx_par[0], ^d); end
`endif
        end
        tick(2);
        vectors += 2;
        if (bus.tx_idle !== 1'b1) begin miscompares++; $display("FAIL single_idle_after: got %b want 1", bus.tx_idle); end
        if (bus.avr_rx !== 1'b1)  begin miscompares++; $display("FAIL single_line_after: got %b want 1", bus.avr_rx); end
    endtask

    task automatic test_fill();
        logic [7:0] exp_q[$];
        logic [7:0] d;
        int mcount = 0;
        bit acc;
        clear_rx();
        for (int i = 0; i < DEPTH + 2; i++) begin
            d = 8'($urandom);
            bus.wr_en = 1'b1; bus.wr_data = d;
            acc = (mcount < DEPTH);
            @(negedge sysclk);
            if (acc) begin exp_q.push_back(d); mcount++; end
            if (i == 1) mcount--;
            vectors += 3;
            if (bus.level !== 4'(mcount)) begin miscompares++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, bus.level, mcount); end
            if (bus.overflow !== !acc)    begin miscompares++; $display("FAIL fill_overflow[%0d]: got %b want %b", i, bus.overflow, !acc); end
            if (bus.full !== (mcount == DEPTH)) begin miscompares++; $display("FAIL fill_full[%0d]: got %b want %b", i, bus.full, mcount == DEPTH); end
        end
        bus.wr_en = 1'b0;
        @(negedge sysclk);
        vectors += 2;
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL fill_ovf_pulse: got %b want 0", bus.overflow); end
        if (bus.level !== 4'(mcount)) begin miscompares++; $display("FAIL fill_level_hold: got %0d want %0d", bus.level, mcount); end
        wait_frames(exp_q.size(), exp_q.size() * FRAME + 50, "fill");
        tick(2 * FRAME);
        vectors++;
        if (rx_byte.size() != exp_q.size()) begin miscompares++; $display("FAIL fill_count: got %0d want %0d", rx_byte.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < rx_byte.size(); k++) begin
            vectors += 2;
            if (rx_byte[k] !== exp_q[k]) begin miscompares++; $display("FAIL fill_data[%0d]: got %h want %h", k, rx_byte[k], exp_q[k]); end
            if (rx_bad[k] !== 1'b0)      begin miscompares++; $display("FAIL fill_framing[%0d]: bad %b", k, rx_bad[k]); end
            if (k > 0) begin
                vectors++;
                if (rx_cyc[k] - rx_cyc[k-1] != FRAME) begin miscompares++; $display("FAIL fill_period[%0d]: got %0d want %0d", k, rx_cyc[k] - rx_cyc[k-1], FRAME); end
            end
        end
    endtask

    task automatic test_busy_hold();
        logic [7:0] d;
        int r;
        bit line_ok = 1, lvl_ok = 1;
        clear_rx();
        bus.avr_rx_busy = 1'b1;
        tick(3);
        d = 8'($urandom);
        do_write(d);
        for (int i = 0; i < 20; i++) begin
            if (bus.avr_rx !== 1'b1) line_ok = 0;
            if (bus.level !== 4'd1)  lvl_ok = 0;
            @(negedge sysclk);
        end
        vectors += 2;
        if (!line_ok) begin miscompares++; $display("FAIL busy_hold_line: got 0 want 1"); end
        if (!lvl_ok)  begin miscompares++; $display("FAIL busy_hold_level: got %0d want 1", bus.level); end
        bus.avr_rx_busy = 1'b0;
        r = cyc;
        wait_frames(1, FRAME + 20, "busy_hold");
        if (rx_byte.size() >= 1) begin
            vectors += 2;
            if (rx_cyc[0] != r + 3) begin miscompares++; $display("FAIL busy_release_latency: start %0d want %0d", rx_cyc[0], r + 3); end
            if (rx_byte[0] !== d)   begin miscompares++; $display("FAIL busy_hold_data: got %h want %h", rx_byte[0], d); end
        end
        tick(3);
    endtask

    task automatic test_busy_mid();
        logic [7:0] d1, d2;
        int w, r;
        clear_rx();
        d1 = 8'h3C;
        d2 = 8'($urandom);
        do_write(d1);
        w = cyc;
        do_write(d2);
        tick(4 * C);
        bus.avr_rx_busy = 1'b1;
        wait_frames(1, FRAME + 20, "busy_mid");
        if (rx_byte.size() >= 1) begin
            vectors += 3;
            if (rx_byte[0] !== d1)  begin miscompares++; $display("FAIL busy_mid_data: got %h want %h", rx_byte[0], d1); end
            if (rx_cyc[0] != w + 1) begin miscompares++; $display("FAIL busy_mid_start: got %0d want %0d", rx_cyc[0], w + 1); end
            if (rx_bad[0] !== 1'b0) begin miscompares++; $display("FAIL busy_mid_framing: bad %b", rx_bad[0]); end
        end
        tick(3 * NB * C);
        vectors += 3;
        if (rx_byte.size() != 1) begin miscompares++; $display("FAIL busy_mid_gated: frames %0d want 1", rx_byte.size()); end
        if (bus.level !== 4'd1)  begin miscompares++; $display("FAIL busy_mid_level: got %0d want 1", bus.level); end
        if (bus.avr_rx !== 1'b1) begin miscompares++; $display("FAIL busy_mid_line: got %b want 1", bus.avr_rx); end
        bus.avr_rx_busy = 1'b0;
        r = cyc;
        wait_frames(2, FRAME + 20, "busy_mid2");
        if (rx_byte.size() >= 2) begin
            vectors += 2;
            if (rx_cyc[1] != r + 3) begin miscompares++; $display("FAIL busy_mid_release: start %0d want %0d", rx_cyc[1], r + 3); end
            if (rx_byte[1] !== d2)  begin miscompares++; $display("FAIL busy_mid_data2: got %h want %h", rx_byte[1], d2); end
        end
        tick(3);
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int w, st;
        bit quiet = 1;
        clear_rx();
        d = 8'($urandom) & 8'hEF;
        do_write(d);
        w = cyc;
        for (int i = 0; i < 3; i++) do_write(8'($urandom));
        st = w + 1;
        tick(st + 5 * C + 1 - cyc);
        vectors++;
        if (bus.avr_rx !== 1'b0) begin miscompares++; $display("FAIL rstmid_bit4: got %b want 0", bus.avr_rx); end
        #1 sysrst = 1'b1;
        #1;
        vectors += 4;
        if (bus.avr_rx !== 1'b1)  begin miscompares++; $display("FAIL rstmid_line: got %b want 1", bus.avr_rx); end
        if (bus.level !== 4'd0)   begin miscompares++; $display("FAIL rstmid_level: got %0d want 0", bus.level); end
        if (bus.tx_idle !== 1'b1) begin miscompares++; $display("FAIL rstmid_idle: got %b want 1", bus.tx_idle); end
        if (bus.full !== 1'b0)    begin miscompares++; $display("FAIL rstmid_full: got %b want 0", bus.full); end
        @(negedge sysclk);
        sysrst = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge sysclk);
            if (bus.avr_rx !== 1'b1) quiet = 0;
        end
        vectors += 2;
        if (!quiet)              begin miscompares++; $display("FAIL rstmid_quiet: line went low, want 1"); end
        if (rx_byte.size() != 0) begin miscompares++; $display("FAIL rstmid_frames: got %0d want 0", rx_byte.size()); end
    endtask

    initial begin
        test_reset();
        test_single(8'hA5);
        test_single(8'($urandom));
        test_single(8'($urandom));
`ifdef AVR_UART_TX_PARITY_EN
        test_single(8'h07);
        test_single(8'h03);
`endif
        test_fill();
        test_busy_hold();
        test_busy_mid();
        test_reset_mid();
        test_single(8'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
